// File: rtl/turing_machine_nsym.sv
// Multi-symbol Turing machine core with host-loaded rule table and tape,
// step limit, single-step mode, abort and halt-reason reporting.
//   state   | meaning
//   S_IDLE  | waiting for start, host may write rules/tape
//   S_FETCH | read tape under head, latch rule entry
//   S_EXEC  | write symbol, move head, update state and step count
//   S_PAUSE | single-step hold, waiting for step pulse
//   S_DONE  | run finished, halt_reason valid, host may write
module turing_machine_nsym #(
    parameter int SYM_W    = 2,
    parameter int ST_W     = 3,
    parameter int TAPE_LEN = 32,
    parameter int STEP_W   = 16,
    localparam int HW      = $clog2(TAPE_LEN),
    localparam int RA_W    = ST_W + SYM_W,
    localparam int RD_W    = SYM_W + 2 + ST_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rule_we,
    input  logic [RA_W-1:0]   rule_addr,
    input  logic [RD_W-1:0]   rule_data,
    input  logic              tape_we,
    input  logic [HW-1:0]     tape_addr,
    input  logic [SYM_W-1:0]  tape_wdata,
    output logic [SYM_W-1:0]  tape_rdata,
    input  logic              start,
    input  logic [HW-1:0]     head_init,
    input  logic [ST_W-1:0]   start_state,
    input  logic [STEP_W-1:0] max_steps,
    input  logic              step_mode,
    input  logic              step,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [1:0]        halt_reason,
    output logic [ST_W-1:0]   cur_state,
    output logic [HW-1:0]     head_pos,
    output logic [STEP_W-1:0] step_count
);

    localparam int NRULE = 2 ** RA_W;
    localparam logic [HW-1:0] LAST = HW'(TAPE_LEN - 1);
    localparam logic [HW:0]   LEN  = (HW + 1)'(TAPE_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t state, state_next;
    logic [1:0] reason_next;

    logic [SYM_W-1:0]  tape  [TAPE_LEN];
    logic [RD_W-1:0]   rules [NRULE];
    logic [RD_W-1:0]   rule_q;
    logic [STEP_W-1:0] limit;

    logic [SYM_W-1:0] w_sym;
    logic [1:0]       move;
    logic [ST_W-1:0]  nxt_state;
    logic             move_left, move_right, at_edge, host_ok;

    assign w_sym      = rule_q[RD_W-1 -: SYM_W];
    assign move       = rule_q[ST_W+1:ST_W];
    assign nxt_state  = rule_q[ST_W-1:0];
    assign move_left  = (move == 2'b10);
    assign move_right = (move == 2'b01);
    assign at_edge    = (move_left && head_pos == '0) || (move_right && head_pos == LAST);
    assign host_ok    = (state == S_IDLE) || (state == S_DONE);

    assign tape_rdata = tape[tape_addr];
    assign busy       = (state == S_FETCH) || (state == S_EXEC) || (state == S_PAUSE);
    assign done       = (state == S_DONE);

    always_comb begin
        state_next  = state;
        reason_next = halt_reason;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    reason_next = 2'b00;
                    if (start_state == '0) begin
                        state_next  = S_DONE;
                        reason_next = 2'b01;
                    end else if ({1'b0, head_init} >= LEN) begin
                        state_next  = S_DONE;
                        reason_next = 2'b10;
                    end else begin
                        state_next = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (limit != '0 && step_count == limit) begin
                    state_next  = S_DONE;
                    reason_next = 2'b11;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (nxt_state == '0) begin
                    state_next  = S_DONE;
                    reason_next = 2'b01;
                end else if (at_edge) begin
                    state_next  = S_DONE;
                    reason_next = 2'b10;
                end else begin
                    state_next = step_mode ? S_PAUSE : S_FETCH;
                end
            end
            S_PAUSE: begin
                if (step || !step_mode) state_next = S_FETCH;
            end
            default: state_next = S_IDLE;
        endcase
        if (abort) begin
            state_next  = S_IDLE;
            reason_next = 2'b00;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            halt_reason <= 2'b00;
            cur_state   <= '0;
            head_pos    <= '0;
            step_count  <= '0;
            limit       <= '0;
            rule_q      <= '0;
            for (int i = 0; i < TAPE_LEN; i++) tape[i] <= '0;
            for (int i = 0; i < NRULE; i++) rules[i] <= '0;
        end else begin
            state       <= state_next;
            halt_reason <= reason_next;
            // Host writes land on the start edge too, so FETCH sees them.
            if (host_ok) begin
                if (rule_we) rules[rule_addr] <= rule_data;
                if (tape_we && {1'b0, tape_addr} < LEN) tape[tape_addr] <= tape_wdata;
                if (start && !abort) begin
                    cur_state  <= start_state;
                    head_pos   <= head_init;
                    step_count <= '0;
                    limit      <= max_steps;
                end
            end
            if (state == S_FETCH && !abort) rule_q <= rules[{cur_state, tape[head_pos]}];
            if (state == S_EXEC && !abort) begin
                tape[head_pos] <= w_sym;
                cur_state      <= nxt_state;
                if (step_count != '1) step_count <= step_count + 1'b1;
                if (!at_edge) begin
                    if (move_right)     head_pos <= head_pos + 1'b1;
                    else if (move_left) head_pos <= head_pos - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_turing_machine_nsym.sv
// Directed bench for turing_machine_nsym: hand-computed programs covering
// halt, tape edge, step limit, single-step, abort, write/start ordering and reset.
module tb_turing_machine_nsym;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rule_we = 1'b0;
    logic [4:0]  rule_addr = '0;
    logic [6:0]  rule_data = '0;
    logic        tape_we = 1'b0;
    logic [4:0]  tape_addr = '0;
    logic [1:0]  tape_wdata = '0;
    logic [1:0]  tape_rdata;
    logic        start = 1'b0;
    logic [4:0]  head_init = '0;
    logic [2:0]  start_state = '0;
    logic [15:0] max_steps = '0;
    logic        step_mode = 1'b0;
    logic        step = 1'b0;
    logic        abort = 1'b0;
    logic        busy, done;
    logic [1:0]  halt_reason;
    logic [2:0]  cur_state;
    logic [4:0]  head_pos;
    logic [15:0] step_count;

    int n_vec = 0;
    int n_err = 0;
    int cyc;

    turing_machine_nsym dut (
        .clock(clock), .reset(reset),
        .rule_we(rule_we), .rule_addr(rule_addr), .rule_data(rule_data),
        .tape_we(tape_we), .tape_addr(tape_addr), .tape_wdata(tape_wdata),
        .tape_rdata(tape_rdata),
        .start(start), .head_init(head_init), .start_state(start_state),
        .max_steps(max_steps), .step_mode(step_mode), .step(step), .abort(abort),
        .busy(busy), .done(done), .halt_reason(halt_reason),
        .cur_state(cur_state), .head_pos(head_pos), .step_count(step_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr_rule(input int st, input int sym, input int ws, input int mv, input int ns);
        rule_we   = 1'b1;
        rule_addr = 5'({st[2:0], sym[1:0]});
        rule_data = 7'({ws[1:0], mv[1:0], ns[2:0]});
        tick();
        rule_we = 1'b0;
    endtask

    task automatic wr_tape(input int a, input int s);
        tape_we    = 1'b1;
        tape_addr  = 5'(a);
        tape_wdata = 2'(s);
        tick();
        tape_we = 1'b0;
    endtask

    task automatic rd_tape(input string tag, input int a, input int exp);
        tape_addr = 5'(a);
        #1;
        chk(tag, 32'(tape_rdata), 32'(exp));
    endtask

    // Cycles counts clock edges from the start edge (inclusive) to done.
    task automatic run(input int hi, input int ss, input int ms, output int cycles);
        head_init   = 5'(hi);
        start_state = 3'(ss);
        max_steps   = 16'(ms);
        start       = 1'b1;
        cycles      = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            start = 1'b0;
            cycles++;
            if (done) break;
        end
        if (!done) chk("run_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_reason", 32'(halt_reason), 32'd0);
        chk("rst_state", 32'(cur_state), 32'd0);
        chk("rst_head", 32'(head_pos), 32'd0);
        chk("rst_steps", 32'(step_count), 32'd0);
        rd_tape("rst_tape3", 3, 0);

        // Binary increment, LSB at cell 0: 3 -> 4
        wr_rule(1, 1, 0, 1, 1);
        wr_rule(1, 0, 1, 0, 0);
        wr_tape(0, 1);
        wr_tape(1, 1);
        run(0, 1, 0, cyc);
        chk("inc_cycles", 32'(cyc), 32'd7);
        chk("inc_reason", 32'(halt_reason), 32'd1);
        chk("inc_steps", 32'(step_count), 32'd3);
        chk("inc_head", 32'(head_pos), 32'd2);
        chk("inc_state", 32'(cur_state), 32'd0);
        chk("inc_busy", 32'(busy), 32'd0);
        rd_tape("inc_t0", 0, 0);
        rd_tape("inc_t1", 1, 0);
        rd_tape("inc_t2", 2, 1);

        // Left move off cell 0: write and state still happen, head stays
        wr_rule(1, 0, 1, 2, 1);
        run(0, 1, 0, cyc);
        chk("edge_cycles", 32'(cyc), 32'd3);
        chk("edge_reason", 32'(halt_reason), 32'd2);
        chk("edge_steps", 32'(step_count), 32'd1);
        chk("edge_head", 32'(head_pos), 32'd0);
        chk("edge_state", 32'(cur_state), 32'd1);
        rd_tape("edge_t0", 0, 1);

        // Two-state loop at cell 5 bounded by max_steps
        wr_rule(1, 0, 0, 0, 2);
        wr_rule(2, 0, 0, 3, 1);
        run(5, 1, 5, cyc);
        chk("lim_cycles", 32'(cyc), 32'd12);
        chk("lim_reason", 32'(halt_reason), 32'd3);
        chk("lim_steps", 32'(step_count), 32'd5);
        chk("lim_state", 32'(cur_state), 32'd2);
        chk("lim_head", 32'(head_pos), 32'd5);

        // Single-step mode, busy host write, abort
        step_mode   = 1'b1;
        head_init   = 5'd5;
        start_state = 3'd1;
        max_steps   = '0;
        start       = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("ss_busy1", 32'(busy), 32'd1);
        chk("ss_steps1", 32'(step_count), 32'd1);
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (4) tick();
        chk("ss_busy2", 32'(busy), 32'd1);
        chk("ss_steps2", 32'(step_count), 32'd2);
        wr_tape(5, 3);
        rd_tape("ss_tape_we_busy", 5, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ss_start_ignored", 32'(step_count), 32'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_done", 32'(done), 32'd0);
        chk("ab_reason", 32'(halt_reason), 32'd0);
        chk("ab_steps", 32'(step_count), 32'd2);
        chk("ab_state", 32'(cur_state), 32'd1);
        chk("ab_head", 32'(head_pos), 32'd5);
        step_mode = 1'b0;

        run(4, 0, 0, cyc);
        chk("s0_cycles", 32'(cyc), 32'd1);
        chk("s0_reason", 32'(halt_reason), 32'd1);
        chk("s0_steps", 32'(step_count), 32'd0);

        // Tape write on the start edge must be seen by the first fetch
        wr_rule(3, 1, 2, 0, 0);
        wr_rule(3, 0, 3, 0, 0);
        tape_we    = 1'b1;
        tape_addr  = 5'd7;
        tape_wdata = 2'd1;
        head_init   = 5'd7;
        start_state = 3'd3;
        max_steps   = '0;
        start       = 1'b1;
        tick();
        start   = 1'b0;
        tape_we = 1'b0;
        repeat (3) tick();
        chk("wst_done", 32'(done), 32'd1);
        rd_tape("wst_t7", 7, 2);

        // Reset in the middle of an unbounded loop
        wr_rule(1, 0, 0, 0, 2);
        head_init   = 5'd5;
        start_state = 3'd1;
        start       = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("mr_busy_before", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        tick();
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_done", 32'(done), 32'd0);
        chk("mr_state", 32'(cur_state), 32'd0);
        begin
            int nz;
            nz = 0;
            for (int a = 0; a < 32; a++) begin
                tape_addr = 5'(a);
                #1;
                if (tape_rdata != 2'd0) nz++;
            end
            chk("mr_tape_nonzero", 32'(nz), 32'd0);
        end
        reset = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
